gnr_lut_node: RTL and testbench

//  Parametrised Boolean-network node for GNR emulation. Holds NUM_COPIES independent state

---
 rtl/gnr_pkg.sv | 13 +
 rtl/gnr_lut_node_if.sv | 28 ++
 rtl/gnr_lut_lane.sv | 84 ++++++++
 rtl/gnr_lut_node.sv | 49 ++++
 tb/tb_gnr_lut_node.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/gnr_pkg.sv
// Shared constants for the GNR Boolean-network nodes.
// Holds common truth tables and default counter / skip field widths.
package gnr_pkg;

    // 3-input truth tables, indexed by {in[2], in[1], in[0]}
    localparam logic [7:0] LUT_AND3 = 8'h80;
    localparam logic [7:0] LUT_OR3  = 8'hFE;
    localparam logic [7:0] LUT_MAJ3 = 8'hE8;

    localparam int CNT_W_DEF  = 8;
    localparam int SKIP_W_DEF = 4;

endpackage

// File: rtl/gnr_lut_node_if.sv
// Control / data bundle of one gnr_lut_node.
// master drives strobes, init values, regulator inputs and threshold; slave returns state,
// stable flags and toggle counters.
interface gnr_lut_node_if #(
    parameter int NUM_IN     = 3,
    parameter int NUM_COPIES = 2,
    parameter int CNT_W      = 8
);
    logic                        en;
    logic                        reset_nos;
    logic [NUM_COPIES-1:0]       start;
    logic [NUM_COPIES-1:0]       init_state;
    logic [NUM_COPIES*NUM_IN-1:0] in_bits;
    logic [CNT_W-1:0]            stable_thr;
    logic [NUM_COPIES-1:0]       state;
    logic [NUM_COPIES-1:0]       stable;
    logic [NUM_COPIES*CNT_W-1:0] toggle_cnt;

    modport master (
        output en, reset_nos, start, init_state, in_bits, stable_thr,
        input  state, stable, toggle_cnt
    );

    modport slave (
        input  en, reset_nos, start, init_state, in_bits, stable_thr,
        output state, stable, toggle_cnt
    );
endinterface

// File: rtl/gnr_lut_lane.sv
// One state lane of a GNR LUT node: truth-table update, decimation, stability/toggle counts.
// Ports: clk, rst (sync, active-high), en, reset_nos, start, init_state, in_bits[NUM_IN],
//        stable_thr -> state, stable, toggle_cnt.
module gnr_lut_lane
    import gnr_pkg::*;
#(
    parameter int                    NUM_IN = 3,
    parameter logic [(1<<NUM_IN)-1:0] LUT   = LUT_AND3,
    parameter int                    SKIP_W = SKIP_W_DEF,
    parameter logic [SKIP_W-1:0]     SKIP   = '0,
    parameter int                    CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              reset_nos,
    input  logic              start,
    input  logic              init_state,
    input  logic [NUM_IN-1:0] in_bits,
    input  logic [CNT_W-1:0]  stable_thr,
    output logic              state,
    output logic              stable,
    output logic [CNT_W-1:0]  toggle_cnt
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [SKIP_W-1:0] SKIP_ONE = SKIP_W'(1);

    logic [SKIP_W-1:0] skip_cnt;
    logic [CNT_W-1:0]  stab_cnt;
    logic [CNT_W-1:0]  stab_nxt;
    logic [CNT_W-1:0]  tog_nxt;
    logic              upd;
    logic              lut_val;
    logic              stable_nxt;

    always_comb begin
        upd      = en && start && (skip_cnt == '0);
        lut_val  = LUT[in_bits];
        stab_nxt = stab_cnt;
        tog_nxt  = toggle_cnt;
        if (upd) begin
            if (lut_val != state) begin
                stab_nxt = '0;
                if (toggle_cnt != CNT_MAX)
                    tog_nxt = toggle_cnt + CNT_ONE;
            end else if (stab_cnt != CNT_MAX) begin
                stab_nxt = stab_cnt + CNT_ONE;
            end
        end
        // Judged on post-update count so stable rises on the threshold edge
        stable_nxt = (stable_thr != '0) && (stab_nxt >= stable_thr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= 1'b0;
            skip_cnt   <= SKIP;
            stab_cnt   <= '0;
            toggle_cnt <= '0;
            stable     <= 1'b0;
        end else if (reset_nos) begin
            state      <= init_state;
            skip_cnt   <= '0;
            stab_cnt   <= '0;
            toggle_cnt <= '0;
            stable     <= 1'b0;
        end else begin
            if (en && start) begin
                if (skip_cnt == '0) begin
                    state    <= lut_val;
                    skip_cnt <= SKIP;
                end else begin
                    skip_cnt <= skip_cnt - SKIP_ONE;
                end
            end
            stab_cnt   <= stab_nxt;
            toggle_cnt <= tog_nxt;
            stable     <= stable_nxt;
        end
    end

endmodule

// File: rtl/gnr_lut_node.sv
// Parametrised Boolean-network node: NUM_COPIES independent lanes of one gene.
// Ports: clk, rst (sync, active-high), bus (gnr_lut_node_if.slave: en, reset_nos, start,
//        init_state, in_bits, stable_thr -> state, stable, toggle_cnt).
module gnr_lut_node
    import gnr_pkg::*;
#(
    parameter int                         NUM_IN     = 3,
    parameter int                         NUM_COPIES = 2,
    parameter logic [(1<<NUM_IN)-1:0]      LUT        = LUT_AND3,
    parameter int                         SKIP_W     = SKIP_W_DEF,
    parameter logic [NUM_COPIES*SKIP_W-1:0] SKIP_VEC  = {4'd0, 4'd1},
    parameter int                         CNT_W      = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    gnr_lut_node_if.slave  bus
);

    logic [NUM_COPIES-1:0]       state_w;
    logic [NUM_COPIES-1:0]       stable_w;
    logic [NUM_COPIES*CNT_W-1:0] tog_w;

    for (genvar c = 0; c < NUM_COPIES; c++) begin : g_lane
        gnr_lut_lane #(
            .NUM_IN (NUM_IN),
            .LUT    (LUT),
            .SKIP_W (SKIP_W),
            .SKIP   (SKIP_VEC[c*SKIP_W +: SKIP_W]),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .en         (bus.en),
            .reset_nos  (bus.reset_nos),
            .start      (bus.start[c]),
            .init_state (bus.init_state[c]),
            .in_bits    (bus.in_bits[c*NUM_IN +: NUM_IN]),
            .stable_thr (bus.stable_thr),
            .state      (state_w[c]),
            .stable     (stable_w[c]),
            .toggle_cnt (tog_w[c*CNT_W +: CNT_W])
        );
    end

    assign bus.state      = state_w;
    assign bus.stable     = stable_w;
    assign bus.toggle_cnt = tog_w;

endmodule

// File: tb/tb_gnr_lut_node.sv
// Self-checking bench for gnr_lut_node: vector table, corner sequences, random vs model.
// Three instances: AND3 with skip {0,1}, MAJ3 without skip, MAJ3 with 2-bit counters.
module tb_gnr_lut_node;
    import gnr_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gnr_lut_node_if #(.NUM_IN(3), .NUM_COPIES(2), .CNT_W(8)) b0 ();
    gnr_lut_node_if #(.NUM_IN(3), .NUM_COPIES(2), .CNT_W(8)) b1 ();
    gnr_lut_node_if #(.NUM_IN(3), .NUM_COPIES(2), .CNT_W(2)) b2 ();

    gnr_lut_node u0 (.clk(clk), .rst(rst), .bus(b0));

    gnr_lut_node #(.LUT(LUT_MAJ3), .SKIP_VEC(8'h00)) u1 (
        .clk(clk), .rst(rst), .bus(b1));

    gnr_lut_node #(.LUT(LUT_MAJ3), .SKIP_VEC(8'h00), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .bus(b2));

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic       nos;
        logic [1:0] start;
        logic [1:0] init;
        logic [5:0] in;
        logic [7:0] thr;
        logic [1:0] e_state;
        logic [1:0] e_stable;
        logic [7:0] e_t1;
        logic [7:0] e_t0;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic e, logic n, logic [1:0] s,
                                logic [1:0] i, logic [5:0] in, logic [7:0] th,
                                logic [1:0] es, logic [1:0] eb,
                                logic [7:0] t1, logic [7:0] t0);
        vec_t v;
        v.rst = r; v.en = e; v.nos = n; v.start = s; v.init = i;
        v.in = in; v.thr = th; v.e_state = es; v.e_stable = eb;
        v.e_t1 = t1; v.e_t0 = t0;
        return v;
    endfunction

    // Reference model state for u0 (AND3, lane0 skips 1 start, lane1 none)
    int m_st[2];
    int m_wait[2];
    int m_stab[2];
    int m_tog[2];
    int m_stable[2];
    int skipv[2] = '{1, 0};

    task automatic model_edge(input logic r, input logic e, input logic n,
                              input logic [1:0] s, input logic [1:0] init,
                              input logic [5:0] in, input logic [7:0] thr);
        for (int c = 0; c < 2; c++) begin
            if (r) begin
                m_st[c] = 0; m_wait[c] = skipv[c];
                m_stab[c] = 0; m_tog[c] = 0; m_stable[c] = 0;
            end else if (n) begin
                m_st[c] = int'(init[c]); m_wait[c] = 0;
                m_stab[c] = 0; m_tog[c] = 0; m_stable[c] = 0;
            end else begin
                if (e && s[c]) begin
                    if (m_wait[c] == 0) begin
                        int idx;
                        int nx;
                        idx = int'((in >> (3 * c)) & 6'h7);
                        // AND3: only all-ones input yields 1
                        nx = (idx == 7) ? 1 : 0;
                        if (nx != m_st[c]) begin
                            m_tog[c] = (m_tog[c] < 255) ? m_tog[c] + 1 : 255;
                            m_stab[c] = 0;
                        end else begin
                            m_stab[c] = (m_stab[c] < 255) ? m_stab[c] + 1 : 255;
                        end
                        m_st[c] = nx;
                        m_wait[c] = skipv[c];
                    end else begin
                        m_wait[c] = m_wait[c] - 1;
                    end
                end
                m_stable[c] = (thr != 0 && m_stab[c] >= int'(thr)) ? 1 : 0;
            end
        end
    endtask

    task automatic idle_all();
        b0.en = 0; b0.reset_nos = 0; b0.start = 0; b0.init_state = 0;
        b0.in_bits = 0; b0.stable_thr = 0;
        b1.en = 0; b1.reset_nos = 0; b1.start = 0; b1.init_state = 0;
        b1.in_bits = 0; b1.stable_thr = 0;
        b2.en = 0; b2.reset_nos = 0; b2.start = 0; b2.init_state = 0;
        b2.in_bits = 0; b2.stable_thr = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_all();

        // Vector table on u0
        tv.push_back(mk(1,0,0,2'b00,2'b00,6'h00,8'd0, 2'b00,2'b00,8'd0,8'd0));
        tv.push_back(mk(0,0,1,2'b00,2'b11,6'h00,8'd2, 2'b11,2'b00,8'd0,8'd0));
        tv.push_back(mk(0,1,0,2'b11,2'b11,6'h3F,8'd2, 2'b11,2'b00,8'd0,8'd0));
        tv.push_back(mk(0,1,0,2'b11,2'b11,6'h3F,8'd2, 2'b11,2'b10,8'd0,8'd0));
        tv.push_back(mk(0,1,0,2'b11,2'b11,6'h3F,8'd2, 2'b11,2'b11,8'd0,8'd0));
        tv.push_back(mk(0,1,0,2'b11,2'b11,6'h3F,8'd2, 2'b11,2'b11,8'd0,8'd0));
        tv.push_back(mk(0,1,0,2'b00,2'b11,6'h3F,8'd4, 2'b11,2'b10,8'd0,8'd0));
        tv.push_back(mk(0,1,0,2'b00,2'b11,6'h3F,8'd5, 2'b11,2'b00,8'd0,8'd0));
        tv.push_back(mk(0,1,0,2'b00,2'b11,6'h3F,8'd0, 2'b11,2'b00,8'd0,8'd0));
        tv.push_back(mk(0,1,0,2'b00,2'b11,6'h3F,8'd2, 2'b11,2'b11,8'd0,8'd0));
        tv.push_back(mk(0,0,0,2'b11,2'b11,6'h00,8'd2, 2'b11,2'b11,8'd0,8'd0));
        tv.push_back(mk(0,1,1,2'b11,2'b01,6'h00,8'd2, 2'b01,2'b00,8'd0,8'd0));
        tv.push_back(mk(0,1,0,2'b11,2'b01,6'h00,8'd2, 2'b00,2'b00,8'd0,8'd1));
        tv.push_back(mk(0,1,0,2'b11,2'b01,6'h00,8'd2, 2'b00,2'b10,8'd0,8'd1));
        tv.push_back(mk(1,1,0,2'b11,2'b00,6'h3F,8'd2, 2'b00,2'b00,8'd0,8'd0));
        tv.push_back(mk(0,1,0,2'b01,2'b00,6'h07,8'd2, 2'b00,2'b00,8'd0,8'd0));
        tv.push_back(mk(0,1,0,2'b01,2'b00,6'h07,8'd2, 2'b01,2'b00,8'd0,8'd1));
        tv.push_back(mk(1,1,1,2'b11,2'b11,6'h3F,8'd2, 2'b00,2'b00,8'd0,8'd0));
        tv.push_back(mk(0,0,0,2'b00,2'b11,6'h3F,8'd2, 2'b00,2'b00,8'd0,8'd0));

        foreach (tv[i]) begin
            rst = tv[i].rst;
            b0.en = tv[i].en; b0.reset_nos = tv[i].nos;
            b0.start = tv[i].start; b0.init_state = tv[i].init;
            b0.in_bits = tv[i].in; b0.stable_thr = tv[i].thr;
            tick();
            check($sformatf("vec%0d", i),
                  {12'd0, b0.state, b0.stable, b0.toggle_cnt},
                  {12'd0, tv[i].e_state, tv[i].e_stable, tv[i].e_t1, tv[i].e_t0});
        end
        rst = 1'b0;
        idle_all();

        // Majority lane1: alternating inputs toggle every update
        b1.reset_nos = 1; b1.init_state = 2'b00; b1.stable_thr = 8'd2;
        tick();
        b1.reset_nos = 0; b1.en = 1; b1.start = 2'b10;
        for (int k = 0; k < 4; k++) begin
            b1.in_bits = (k % 2 == 0) ? 6'b011_000 : 6'b001_000;
            tick();
            check($sformatf("maj_state%0d", k), {31'd0, b1.state[1]},
                  (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("maj_stable%0d", k), {31'd0, b1.stable[1]}, 32'd0);
        end
        check("maj_tog", {24'd0, b1.toggle_cnt[15:8]}, 32'd4);

        // Threshold 3 on lane0: one change then three unchanged updates
        b1.en = 0; b1.start = 0; b1.reset_nos = 1; b1.init_state = 2'b00;
        b1.stable_thr = 8'd3;
        tick();
        b1.reset_nos = 0; b1.en = 1; b1.start = 2'b01; b1.in_bits = 6'b000_111;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("thr3_stable%0d", k), {31'd0, b1.stable[0]},
                  (k == 3) ? 32'd1 : 32'd0);
        end
        b1.start = 0; b1.stable_thr = 8'd0;
        tick();
        check("thr0_clears", {31'd0, b1.stable[0]}, 32'd0);
        b1.en = 0;

        // 2-bit counters: saturate without wrap
        b2.reset_nos = 1; b2.init_state = 2'b11; b2.stable_thr = 2'd3;
        tick();
        b2.reset_nos = 0; b2.en = 1; b2.start = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            b2.in_bits = (k % 2 == 1) ? 6'b000_111 : 6'b111_111;
            tick();
            check($sformatf("sat_stable%0d", k), {31'd0, b2.stable[0]},
                  (k >= 3) ? 32'd1 : 32'd0);
            check($sformatf("sat_state%0d", k), {30'd0, b2.state},
                  (k % 2 == 1) ? 32'd1 : 32'd3);
        end
        check("sat_tog", {28'd0, b2.toggle_cnt}, 32'h0000_000C);
        b2.en = 0; b2.start = 0;

        // Randomised run on u0 against the model
        rst = 1'b1;
        model_edge(1, 0, 0, 2'b00, 2'b00, 6'h00, 8'd0);
        tick();
        rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic r, e, nz;
            logic [1:0] s, ini;
            logic [5:0] in;
            logic [7:0] th;
            r   = ($urandom_range(0, 99) < 2);
            nz  = ($urandom_range(0, 99) < 5);
            e   = ($urandom_range(0, 99) < 80);
            s   = 2'($urandom);
            ini = 2'($urandom);
            // bias toward all-ones lanes so AND3 outputs vary
            in  = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'($urandom);
            th  = 8'($urandom_range(0, 4));
            rst = r; b0.en = e; b0.reset_nos = nz; b0.start = s;
            b0.init_state = ini; b0.in_bits = in; b0.stable_thr = th;
            model_edge(r, e, nz, s, ini, in, th);
            tick();
            check($sformatf("rnd%0d", n),
                  {12'd0, b0.state, b0.stable, b0.toggle_cnt},
                  {12'd0, 1'(m_st[1]), 1'(m_st[0]), 1'(m_stable[1]),
                   1'(m_stable[0]), 8'(m_tog[1]), 8'(m_tog[0])});
        end
        rst = 1'b0;
        idle_all();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
